// File: rtl/lfsr_req_scheduler.sv
// Round-robin scheduler sharing one external Galois LFSR among NUM_REQ requesters.
// Sequences seed loads, steps the LFSR once per delivered bit and returns the masked result.
module lfsr_req_scheduler #(
    parameter int N       = 32,
    parameter int NUM_REQ = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [2*NUM_REQ-1:0]   req_wsel,
    input  logic                   seed_ld,
    input  logic [N-1:0]           seed_i,
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   rnd_valid,
    output logic [N-1:0]           rnd_data,
    output logic                   busy,
    output logic                   lfsr_en,
    output logic                   lfsr_ld,
    output logic                   lfsr_sel0,
    output logic                   lfsr_sel1,
    output logic [N-1:0]           lfsr_seed,
    input  logic [N-1:0]           lfsr_q
);

    localparam int unsigned NR = NUM_REQ;
    localparam int          PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STEP,
        DONE
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [PW-1:0]        r_rr_ptr;
    logic [PW-1:0]        r_winner;
    logic [1:0]           r_sel;
    logic [5:0]           r_cnt;
    logic                 r_seed_pending;
    logic [N-1:0]         r_seed;
    logic [N-1:0]         r_data;
    logic [NUM_REQ-1:0]   r_gnt;
    logic                 r_valid;

    logic [PW-1:0]        w_idx;
    logic [PW-1:0]        w_win_idx;
    logic [1:0]           w_win_wsel;
    logic                 w_any;
    logic [N-1:0]         w_mask;
    logic [NUM_REQ-1:0]   w_onehot;

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        w_idx      = '0;
        w_win_idx  = '0;
        w_win_wsel = '0;
        w_any      = 1'b0;
        for (int unsigned i = 0; i < NR; i++) begin
            w_idx = PW'((32'(r_rr_ptr) + i) % NR);
            if (!w_any && req[w_idx]) begin
                w_any      = 1'b1;
                w_win_idx  = w_idx;
                w_win_wsel = req_wsel[{w_idx, 1'b0} +: 2];
            end
        end
    end

    always_comb begin
        w_mask = '0;
        for (int unsigned b = 0; b < N; b++) begin
            w_mask[b] = (b < (32'd32 >> r_sel));
        end
    end

    assign w_onehot = NUM_REQ'(1) << r_winner;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (r_seed_pending) begin
                    w_next = LOAD;
                end else if (w_any) begin
                    w_next = STEP;
                end
            end
            LOAD:    w_next = IDLE;
            STEP:    if (r_cnt == 6'd1) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr       <= '0;
            r_winner       <= '0;
            r_sel          <= '0;
            r_cnt          <= '0;
            r_seed_pending <= 1'b0;
            r_seed         <= '0;
            r_data         <= '0;
            r_gnt          <= '0;
            r_valid        <= 1'b0;
        end else begin
            r_gnt   <= '0;
            r_valid <= 1'b0;
            // A seed arriving in the LOAD cycle keeps the request pending for the new value.
            if (seed_ld) begin
                r_seed_pending <= 1'b1;
                r_seed         <= seed_i;
            end else if (r_state == LOAD) begin
                r_seed_pending <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (!r_seed_pending && w_any) begin
                        r_winner <= w_win_idx;
                        r_sel    <= w_win_wsel;
                        r_cnt    <= 6'd32 >> w_win_wsel;
                    end
                end
                STEP: r_cnt <= r_cnt - 6'd1;
                DONE: begin
                    r_data   <= lfsr_q & w_mask;
                    r_valid  <= 1'b1;
                    r_gnt    <= w_onehot;
                    r_rr_ptr <= (r_winner == PW'(NUM_REQ - 1)) ? '0 : r_winner + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign rnd_valid = r_valid;
    assign rnd_data  = r_data;
    assign busy      = (r_state != IDLE);
    assign lfsr_en   = (r_state == STEP);
    assign lfsr_ld   = (r_state == LOAD);
    assign lfsr_sel0 = r_sel[0];
    assign lfsr_sel1 = r_sel[1];
    assign lfsr_seed = r_seed;

endmodule

// File: tb/tb_lfsr_req_scheduler.sv
// Bench for lfsr_req_scheduler: external left-shift Galois LFSR plus a behavioural
// arbitration/result model; directed and $urandom request mixes.
module tb_lfsr_req_scheduler;

    localparam int          N    = 32;
    localparam int          NR   = 4;
    localparam logic [31:0] TAPS = 32'h000000C5;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic [NR-1:0]     req      = '0;
    logic [2*NR-1:0]   req_wsel = '0;
    logic              seed_ld  = 1'b0;
    logic [N-1:0]      seed_i   = '0;
    logic [NR-1:0]     gnt;
    logic              rnd_valid;
    logic [N-1:0]      rnd_data;
    logic              busy;
    logic              lfsr_en;
    logic              lfsr_ld;
    logic              lfsr_sel0;
    logic              lfsr_sel1;
    logic [N-1:0]      lfsr_seed;
    logic [N-1:0]      lfsr_reg = '0;

    int          n_checks = 0;
    int          n_err    = 0;
    int          en_cnt   = 0;
    int          ld_cnt   = 0;
    int          gnt_cnt  = 0;
    logic [31:0] mlfsr    = '0;
    int          m_ptr    = 0;

    lfsr_req_scheduler #(.N(N), .NUM_REQ(NR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_wsel  (req_wsel),
        .seed_ld   (seed_ld),
        .seed_i    (seed_i),
        .gnt       (gnt),
        .rnd_valid (rnd_valid),
        .rnd_data  (rnd_data),
        .busy      (busy),
        .lfsr_en   (lfsr_en),
        .lfsr_ld   (lfsr_ld),
        .lfsr_sel0 (lfsr_sel0),
        .lfsr_sel1 (lfsr_sel1),
        .lfsr_seed (lfsr_seed),
        .lfsr_q    (lfsr_reg)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lstep(input logic [31:0] v);
        return {v[30:0], 1'b0} ^ (v[31] ? TAPS : 32'h0);
    endfunction

    function automatic logic [31:0] adv(input logic [31:0] v, input int n);
        logic [31:0] r = v;
        for (int k = 0; k < n; k++) r = lstep(r);
        return r;
    endfunction

    function automatic logic [31:0] wmask(input logic [1:0] code);
        int w = 32 >> code;
        return (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    endfunction

    function automatic int pick(input logic [NR-1:0] m, input int p);
        for (int k = 0; k < NR; k++) if (m[(p + k) % NR]) return (p + k) % NR;
        return -1;
    endfunction

    // External LFSR: not reset by this block, so it keeps its value across rst_n.
    always @(posedge clk) begin
        if (lfsr_ld) lfsr_reg <= lfsr_seed;
        else if (lfsr_en) lfsr_reg <= lstep(lfsr_reg);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (lfsr_en) en_cnt++;
        if (lfsr_ld) ld_cnt++;
        if (gnt != '0) gnt_cnt++;
        chk("en_ld_exclusive", 64'(lfsr_en & lfsr_ld), 64'd0);
        chk("valid_vs_gnt", 64'(rnd_valid), 64'(|gnt));
        chk("gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_gnt"}, 64'(gnt), 64'd0);
        chk({tag, "_valid"}, 64'(rnd_valid), 64'd0);
        chk({tag, "_data"}, 64'(rnd_data), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_en"}, 64'(lfsr_en), 64'd0);
        chk({tag, "_ld"}, 64'(lfsr_ld), 64'd0);
        chk({tag, "_sel"}, 64'({lfsr_sel1, lfsr_sel0}), 64'd0);
        chk({tag, "_seed"}, 64'(lfsr_seed), 64'd0);
    endtask

    task automatic load_seed(input logic [31:0] s);
        int  t   = 0;
        bit  seen = 1'b0;
        seed_ld = 1'b1;
        seed_i  = s;
        tick();
        seed_ld = 1'b0;
        ld_cnt  = 0;
        while (!seen && t < 8) begin
            tick();
            t++;
            if (lfsr_ld) begin
                seen = 1'b1;
                chk("seed_value_on_ld", 64'(lfsr_seed), 64'(s));
            end
        end
        chk("seed_ld_seen", 64'(seen), 64'd1);
        tick();
        chk("seed_ld_count", 64'(ld_cnt), 64'd1);
        chk("seed_loaded", 64'(lfsr_reg), 64'(s));
        mlfsr = s;
    endtask

    // Serve every requester in mask; each is dropped on its own grant.
    task automatic serve(input logic [NR-1:0] mask, input logic [2*NR-1:0] ws);
        logic [NR-1:0] pend = mask;
        int            win, w, t;
        bit            got;
        logic [1:0]    code;
        req_wsel = ws;
        req      = mask;
        en_cnt   = 0;
        while (pend != '0) begin
            win  = pick(pend, m_ptr);
            code = ws[2*win +: 2];
            w    = 32 >> code;
            t    = 0;
            got  = 1'b0;
            while (!got && t < 100) begin
                tick();
                t++;
                if (gnt != '0) got = 1'b1;
            end
            chk("grant_arrived", 64'(got), 64'd1);
            if (!got) begin
                req = '0;
                return;
            end
            mlfsr = adv(mlfsr, w);
            chk("grant_owner", 64'(gnt), 64'(NR'(1) << win));
            chk("grant_latency", 64'(t), 64'(w + 2));
            chk("step_count", 64'(en_cnt), 64'(w));
            chk("rnd_data", 64'(rnd_data), 64'(mlfsr & wmask(code)));
            chk("sel_held", 64'({lfsr_sel1, lfsr_sel0}), 64'(code));
            m_ptr     = (win + 1) % NR;
            pend[win] = 1'b0;
            req[win]  = 1'b0;
            en_cnt    = 0;
        end
    endtask

    task automatic long_req_seed(input int idx, input logic [31:0] s1, input bit two,
                                 input logic [31:0] s2);
        int          t     = 0;
        bit          got   = 1'b0;
        bit          sent1 = 1'b0;
        bit          sent2 = 1'b0;
        logic [31:0] last;
        int          win;
        req_wsel = '0;
        req      = '0;
        req[idx] = 1'b1;
        win      = pick(req, m_ptr);
        en_cnt   = 0;
        ld_cnt   = 0;
        while (!got && t < 100) begin
            tick();
            t++;
            seed_ld = 1'b0;
            if (gnt != '0) got = 1'b1;
            else if (!sent1 && en_cnt == 10) begin
                seed_ld = 1'b1; seed_i = s1; sent1 = 1'b1;
            end else if (two && !sent2 && en_cnt == 20) begin
                seed_ld = 1'b1; seed_i = s2; sent2 = 1'b1;
            end
        end
        seed_ld = 1'b0;
        req     = '0;
        last    = two ? s2 : s1;
        chk("seedop_grant_arrived", 64'(got), 64'd1);
        mlfsr = adv(mlfsr, 32);
        chk("seedop_owner", 64'(gnt), 64'(NR'(1) << win));
        chk("seedop_latency", 64'(t), 64'd34);
        chk("seedop_steps", 64'(en_cnt), 64'd32);
        chk("seedop_no_early_ld", 64'(ld_cnt), 64'd0);
        chk("seedop_data", 64'(rnd_data), 64'(mlfsr));
        m_ptr = (win + 1) % NR;
        tick();
        chk("seedop_ld_follows", 64'(lfsr_ld), 64'd1);
        chk("seedop_seed_value", 64'(lfsr_seed), 64'(last));
        tick();
        chk("seedop_lfsr_loaded", 64'(lfsr_reg), 64'(last));
        chk("seedop_single_ld", 64'(ld_cnt), 64'd1);
        chk("seedop_idle", 64'(busy), 64'd0);
        mlfsr = last;
    endtask

    initial begin
        int          t, win, g0;
        bit          got;
        logic [2*NR-1:0] ws;
        int          idx;

        // Reset and quiet period
        tick();
        chk_idle("reset");
        rst_n  = 1'b1;
        en_cnt = 0;
        ld_cnt = 0;
        repeat (20) tick();
        chk_idle("quiet");
        chk("quiet_no_en", 64'(en_cnt), 64'd0);
        chk("quiet_no_ld", 64'(ld_cnt), 64'd0);
        chk("quiet_no_gnt", 64'(gnt_cnt), 64'd0);

        // Seed then a 4-bit request from requester 0
        load_seed(32'h8000_0001);
        serve(4'b0001, 8'hFF);
        chk("seed4_data_value", 64'(rnd_data), 64'h8);
        chk("seed4_lfsr_value", 64'(lfsr_reg), 64'h638);

        // Round robin with all requests held, 4-bit widths
        rst_n = 1'b0;
        #1;
        chk_idle("rr_reset");
        tick();
        rst_n  = 1'b1;
        m_ptr  = 0;
        req_wsel = '1;
        req    = '1;
        en_cnt = 0;
        for (int g = 0; g < 6; g++) begin
            win = pick(req, m_ptr);
            t   = 0;
            got = 1'b0;
            while (!got && t < 100) begin
                tick();
                t++;
                if (gnt != '0) got = 1'b1;
            end
            chk("rr_grant_arrived", 64'(got), 64'd1);
            mlfsr = adv(mlfsr, 4);
            chk("rr_owner", 64'(gnt), 64'(NR'(1) << win));
            chk("rr_spacing", 64'(t), 64'd6);
            chk("rr_steps", 64'(en_cnt), 64'd4);
            chk("rr_data", 64'(rnd_data), 64'(mlfsr & 32'hF));
            m_ptr  = (win + 1) % NR;
            en_cnt = 0;
        end
        req = '0;
        tick();

        // Each width code on a random requester, then random request mixes
        for (int c = 0; c < 4; c++) begin
            idx = $urandom_range(0, NR - 1);
            ws  = 2*NR'($urandom);
            ws[2*idx +: 2] = 2'(c);
            serve(NR'(1) << idx, ws);
        end
        for (int r = 0; r < 8; r++) begin
            serve(NR'($urandom_range(1, (1 << NR) - 1)), 2*NR'($urandom));
        end

        // Seeds arriving mid-operation
        long_req_seed($urandom_range(0, NR - 1), 32'h1234_5678, 1'b0, 32'h0);
        serve(4'b1010, 8'b01_00_10_11);
        long_req_seed($urandom_range(0, NR - 1), 32'h1234_5678, 1'b1, 32'hCAFE_F00D);
        serve(4'b1111, 2*NR'($urandom));

        // Reset in the middle of a 16-step operation
        req_wsel = 8'b01_01_01_01;
        req      = '1;
        en_cnt   = 0;
        t        = 0;
        while (en_cnt < 7 && t < 50) begin
            tick();
            t++;
        end
        chk("midrst_reached_step7", 64'(en_cnt), 64'd7);
        rst_n = 1'b0;
        #1;
        chk_idle("midrst");
        g0 = gnt_cnt;
        req = '0;
        tick();
        tick();
        rst_n = 1'b1;
        m_ptr = 0;
        repeat (20) tick();
        chk("midrst_no_gnt", 64'(gnt_cnt), 64'(g0));
        load_seed(32'h0BAD_F00D);
        chk("midrst_no_gnt_after_seed", 64'(gnt_cnt), 64'(g0));
        serve(4'b1111, 8'b01_01_01_01);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

endmodule
